ret_addr_stack: RTL
===================

Name: ret_addr_stack

Overview:
- Return-address stack (RAS) that consumes the decode-stage link signals.
- Call-type instructions (JAL, JALR, BGEZAL, BLTZAL; linkPC asserted) push PC+8.
- A decoded `jr $31` pops the top entry and offers it as the predicted return target.
- A one-entry pending tracker compares each popped prediction with the target resolved in execute and flags mispredictions.

Parameters:
- DEPTH, 8, number of stack entries; power of two, 2..32.
- PTR_W, 3, log2(DEPTH).
- AW, 32, address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stallD  in  1  decode stalled; suppresses push/pop this cycle.
- flushD  in  1  decode flush; clears stack and pending tracker.
- pushD  in  1  call decoded (linkPCD of the instruction in D).
- pcD  in  AW  PC of the instruction in D.
- popD  in  1  `jr $31` decoded in D.
- pred_valid  out  1  top entry valid (count != 0); combinational.
- pred_addr  out  AW  top entry value; combinational; 0 when empty.
- resolveE  in  1  return instruction resolved in E this cycle.
- targetE  in  AW  actual return target from E.
- mispredict  out  1  registered one-cycle pulse, prediction wrong.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular array of DEPTH entries, top pointer `tp` (PTR_W bits, wraps modulo DEPTH), occupancy `count`.
- Reset (rst=1 at edge): tp=0, count=0, all entries 0, pend_valid=0, mispredict=0. pred_valid=0 and pred_addr=0 follow combinationally. rst overrides every other input.
- Effective operations: push_eff = pushD & ~stallD & ~flushD; pop_eff = popD & ~stallD & ~flushD.
- Push only: tp <= tp+1 (wraps); entry[tp+1] <= pcD + 8, truncated mod 2^AW, so 0xFFFFFFFC -> 0x00000004. count <= min(count+1, DEPTH).
- Full push: when count==DEPTH the oldest entry is silently overwritten and count stays DEPTH.
- Pop only, count>0: tp <= tp-1; count <= count-1; pend_valid <= 1; pend_addr <= entry[tp], the value currently on pred_addr.
- Pop only, count==0 (underflow): tp and count unchanged; pend_valid <= 1 with pend_addr <= 0, so the resolve always flags a mispredict.
- Simultaneous push and pop (e.g. `jalr $31,$31`): the pop happens first, then the push into the same slot. entry[tp] <= pcD+8, tp and count unchanged. pend_addr latches the old top. If count==0: entry[tp] <= pcD+8 and count <= 1.
- Resolve: when resolveE & pend_valid, next cycle mispredict <= (targetE != pend_addr), and pend_valid <= 0 unless a new pop_eff occurs in the same cycle, in which case pend is reloaded. resolveE with pend_valid=0 is ignored (mispredict <= 0).
- mispredict is high for exactly one cycle per mismatching resolve; otherwise 0.
- flushD (rst=0): tp=0, count=0, pend_valid=0 next cycle. Entries keep their values but are unreachable. mispredict <= 0, and a resolve in the same cycle is discarded.
- stallD: blocks only push/pop. Resolve/mispredict logic is unaffected.
- Latency: a push is visible on pred_addr the cycle after the edge. A pop exposes the next-lower entry the cycle after the edge. mispredict appears 1 cycle after resolveE.
- No combinational path from resolveE/targetE to any output.

Test Plan:
- Reset then push pcD=0x00400000 -> next cycle pred_valid=1, pred_addr=0x00400008, count=1. Then pop -> count=0, pred_valid=0, pred_addr=0.
- Push 9 calls with pcD=0x100,0x200,...,0x900 (DEPTH=8) -> count=8, pred_addr=0x908. Then 8 pops expose 0x808,...,0x208, confirming 0x108 was overwritten; then count=0.
- Pop on empty, then resolveE with targetE=0x00400010 one cycle later -> mispredict=1 for exactly one cycle; count stays 0.
- Push 0x1000, pop, resolveE targetE=0x1008 -> mispredict stays 0. Repeat with targetE=0x100C -> one-cycle mispredict pulse.
- Simultaneous push/pop with count=2, top=0x2008, pcD=0x3000 -> count=2, pred_addr=0x3008, pend_addr=0x2008. Push with pcD=0xFFFFFFFC -> entry 0x00000004.
- stallD=1 with pushD=popD=1 -> no state change. flushD with count=5 and pend_valid=1 -> count=0, pred_valid=0, a following resolveE gives no mispredict. rst asserted mid-sequence -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ret_addr_stack.sv
// Return-address stack fed by decode-stage link signals, with a one-entry
// tracker that compares each popped prediction against the target resolved in execute.
module ret_addr_stack #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int AW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             pushD,
  input  logic [AW-1:0]    pcD,
  input  logic             popD,
  output logic             pred_valid,
  output logic [AW-1:0]    pred_addr,
  input  logic             resolveE,
  input  logic [AW-1:0]    targetE,
  output logic             mispredict,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);

  logic [AW-1:0]  r_entries [DEPTH];
  logic [PTR_W-1:0] r_tp;
  logic [PTR_W:0] r_count;
  logic           r_pend_valid;
  logic [AW-1:0]  r_pend_addr;
  logic           r_mispredict;

  logic           w_push;
  logic           w_pop;
  logic           w_empty;
  logic [PTR_W-1:0] w_tp_inc;
  logic [PTR_W-1:0] w_tp_dec;
  logic [AW-1:0]  w_top;
  logic [AW-1:0]  w_push_val;

  assign w_push     = pushD & ~stallD & ~flushD;
  assign w_pop      = popD  & ~stallD & ~flushD;
  assign w_empty    = (r_count == '0);
  assign w_tp_inc   = r_tp + 1'b1;
  assign w_tp_dec   = r_tp - 1'b1;
  assign w_top      = w_empty ? '0 : r_entries[r_tp];
  assign w_push_val = pcD + AW'(8);

  assign pred_valid = ~w_empty;
  assign pred_addr  = w_top;
  assign mispredict = r_mispredict;
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tp         <= '0;
      r_count      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_mispredict <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
    end else if (flushD) begin
      // Entries are left as-is; resetting count makes them unreachable.
      r_tp         <= '0;
      r_count      <= '0;
      r_pend_valid <= 1'b0;
      r_mispredict <= 1'b0;
    end else begin
      r_mispredict <= resolveE & r_pend_valid & (targetE != r_pend_addr);
      if (resolveE & r_pend_valid) r_pend_valid <= 1'b0;
      // A new pop reloads the tracker even when the old entry resolves now.
      if (w_pop) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= w_top;
      end
      case ({w_push, w_pop})
        2'b10: begin
          r_tp                <= w_tp_inc;
          r_entries[w_tp_inc] <= w_push_val;
          if (r_count != L_FULL) r_count <= r_count + 1'b1;
        end
        2'b01: begin
          if (!w_empty) begin
            r_tp    <= w_tp_dec;
            r_count <= r_count - 1'b1;
          end
        end
        2'b11: begin
          // Pop then push lands in the same slot.
          r_entries[r_tp] <= w_push_val;
          if (w_empty) r_count <= 1;
        end
        default: ;
      endcase
    end
  end

endmodule
